countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter: the count-down counterpart of the free-running up counter in the counter examples.
- Accepts a start value over a valid/ready load handshake and decrements once per enabled cycle.
- Pulses `expired` for exactly one cycle when the count reaches zero.
- Serves as a timeout/delay source for symbolic-execution test designs alongside the up counter.

Parameters:
- WIDTH, 32, bit width of the count and load value.
- MAX_VALUE, 10000, largest accepted load value; larger loads are clamped to it.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low (0 at a posedge resets).
- load_valid  input  1  load request; `load_value` is valid while high.
- load_value  input  WIDTH  requested start count.
- load_ready  output  1  high when a load can be accepted.
- en  input  1  decrement enable, sampled in RUN only.
- abort  input  1  cancels a running countdown.
- q  output  WIDTH  current count (registered).
- busy  output  1  high in RUN.
- expired  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, q=0, reload register=0, busy=0, expired=0. load_ready=1 from the following cycle. Reset overrides every other input and applies mid-countdown.
- States are IDLE and RUN. busy=(state==RUN). load_ready=(state==IDLE).
- Load acceptance: load is accepted at a posedge where load_valid && load_ready.
  - Clamped value c = (load_value > MAX_VALUE) ? MAX_VALUE : load_value, compared unsigned.
  - c is stored in the reload register.
- Load with c==0: q stays 0, state stays IDLE, expired=1 on the cycle after the accepting edge.
- Load with c>0: q<=c and state<=RUN at the accepting edge. The first decrement can occur at the next edge.
- RUN, priority abort > en:
  - abort=1: q<=0, state<=IDLE, no expired pulse.
  - en=1 and q>1: q<=q-1.
  - en=1 and q==1: q<=0, expired<=1 for one cycle, state<=IDLE.
  - en=0: hold q; expired=0.
- Expiry latency: exactly c enabled cycles after load acceptance. Gaps in en stretch it cycle-for-cycle.
- Wrap rule: q never underflows. Decrement occurs only when q>0; no modular wrap.
- load_valid is ignored in RUN (load_ready=0). The requester holds load_valid/load_value until accepted.
- expired is registered and is deasserted the cycle after any pulse unless re-triggered.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on the en cycle with q==1, expired pulses and q<=reload register; state stays RUN.
  - The reload register is never 0 in RUN.
  - Periodic pulses every reload enabled cycles; only abort or reset return to IDLE.
  - A c==0 load still pulses once and stays IDLE.
- Undefined: one-shot behaviour as above. The reload register may be omitted by synthesis.

Decomposition:
- Package countdown_pkg:
  - state enum {IDLE, RUN} as a 1-bit logic typedef.
  - localparam default WIDTH.
  - count_t typedef logic [WIDTH-1:0] for the default width.
- No sub-module. The clamp is a single comparator; the block is one state register plus a next-state/next-count always_comb.

Test Plan:
- Reset, then load 5 with en held 1 -> q=5,4,3,2,1,0 on successive edges; expired=1 exactly on the cycle q becomes 0; busy falls the same edge; load_ready=1 after.
- Load 3, en pattern 1,0,0,1,1 -> q=3,2,2,2,1,0; expired after the 3rd enabled cycle only.
- Load 20000 with MAX_VALUE=10000 -> q=10000 after accept; load 0 -> q=0, expired pulses once, busy never rises.
- Load 8, 3 decrements, then abort=1 with en=1 -> q=0, state IDLE, expired stays 0; new load accepted next cycle.
- Load 8, 2 decrements, rst=0 for one edge with en=1 -> q=0, busy=0, expired=0; load_valid during RUN ignored (q unaffected, load_ready=0).
- With COUNTDOWN_AUTO_RELOAD_EN, load 2, en=1 for 7 cycles -> q=2,1,2,1,2,1,2; expired on cycles 2, 4, 6; busy stays 1 until abort.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types for the loadable countdown timer.
package countdown_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic {StIdle, StRun} state_e;

  typedef logic [DefaultWidth-1:0] count_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load and a one-cycle expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last load value on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MAX_VALUE = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] MaxC = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] clamped;

  assign clamped = (load_value > MaxC) ? MaxC : load_value;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    expired_d = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_d = clamped;
`endif
          if (clamped == '0) begin
            expired_d = 1'b1;
          end else begin
            q_d     = clamped;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          q_d     = '0;
          state_d = StIdle;
        end else if (en) begin
          if (q_q > One) begin
            q_d = q_q - One;
          end else begin
            // q is 1 here: RUN never holds a zero count.
            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            q_d = reload_q;
`else
            q_d     = '0;
            state_d = StIdle;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      q_q       <= '0;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      expired_q <= expired_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign q          = q_q;
  assign expired    = expired_q;
  assign busy       = (state_q == StRun);
  assign load_ready = (state_q == StIdle);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a randomized run
// against a behavioural model.
module tb_countdown_timer;

  localparam int unsigned W  = 32;
  localparam int unsigned MV = 10000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         load_ready;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         expired;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_reload = '0;
  bit           m_run = 1'b0;
  bit           m_exp = 1'b0;

  countdown_timer #(.WIDTH(W), .MAX_VALUE(MV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [W-1:0] c;
    if (!rst) begin
      m_q = '0; m_run = 1'b0; m_exp = 1'b0; m_reload = '0;
    end else begin
      m_exp = 1'b0;
      if (!m_run) begin
        if (load_valid) begin
          c = (load_value > MV) ? W'(MV) : load_value;
          m_reload = c;
          if (c == 0) m_exp = 1'b1;
          else begin m_q = c; m_run = 1'b1; end
        end
      end else if (abort) begin
        m_q = '0; m_run = 1'b0;
      end else if (en) begin
        if (m_q > 1) m_q = m_q - 1;
        else begin
          m_exp = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          m_q = m_reload;
`else
          m_q = '0; m_run = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; load_valid = 1'b0; load_value = '0; en = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_valid = 1'b1; load_value = 7; en = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (q !== 0 || busy !== 1'b0 || expired !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: q=%0d busy=%b exp=%b rdy=%b, want q=0 busy=0 exp=0 rdy=1",
               q, busy, expired, load_ready);
    end
  endtask

  task automatic test_load5();
    load_valid = 1'b1; load_value = 5; en = 1'b1;
    tick();
    load_valid = 1'b0;
    total++;
    if (q !== 5 || busy !== 1'b1 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL load5_accept: q=%0d busy=%b rdy=%b, want q=5 busy=1 rdy=0", q, busy, load_ready);
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      total++;
      if (q !== W'(i) || expired !== (i == 0) || busy !== (i != 0) || load_ready !== (i == 0)) begin
        bad++;
        $display("FAIL load5_step: q=%0d exp=%b busy=%b rdy=%b, want q=%0d exp=%b busy=%b",
                 q, expired, busy, load_ready, i, i == 0, i != 0);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if (expired !== 1'b0) begin
      bad++;
      $display("FAIL load5_pulse_width: expired=%b, want 0", expired);
    end
  endtask

  task automatic test_en_gaps();
    bit          pat [5]  = '{1, 0, 0, 1, 1};
    int unsigned want [5] = '{2, 2, 2, 1, 0};
    load_valid = 1'b1; load_value = 3;
    tick();
    load_valid = 1'b0;
    total++;
    if (q !== 3) begin bad++; $display("FAIL gaps_accept: q=%0d, want 3", q); end
    for (int i = 0; i < 5; i++) begin
      en = pat[i];
      tick();
      total++;
      if (q !== W'(want[i]) || expired !== (i == 4)) begin
        bad++;
        $display("FAIL gaps_step%0d: q=%0d exp=%b, want q=%0d exp=%b", i, q, expired, want[i], i == 4);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_clamp_and_zero();
    load_valid = 1'b1; load_value = 20000;
    tick();
    load_valid = 1'b0;
    total++;
    if (q !== W'(MV) || busy !== 1'b1) begin
      bad++;
      $display("FAIL clamp: q=%0d busy=%b, want q=%0d busy=1", q, busy, MV);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    load_valid = 1'b1; load_value = 0;
    tick();
    load_valid = 1'b0;
    total++;
    if (q !== 0 || busy !== 1'b0 || expired !== 1'b1) begin
      bad++;
      $display("FAIL zero_load: q=%0d busy=%b exp=%b, want q=0 busy=0 exp=1", q, busy, expired);
    end
    tick();
    total++;
    if (busy !== 1'b0 || expired !== 1'b0) begin
      bad++;
      $display("FAIL zero_load_after: busy=%b exp=%b, want 0 0", busy, expired);
    end
  endtask

  task automatic test_abort();
    load_valid = 1'b1; load_value = 8;
    tick();
    load_valid = 1'b0; en = 1'b1;
    repeat (3) tick();
    total++;
    if (q !== 5) begin bad++; $display("FAIL abort_pre: q=%0d, want 5", q); end
    abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    total++;
    if (q !== 0 || busy !== 1'b0 || expired !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort: q=%0d busy=%b exp=%b rdy=%b, want 0 0 0 1", q, busy, expired, load_ready);
    end
    load_valid = 1'b1; load_value = 4;
    tick();
    load_valid = 1'b0;
    total++;
    if (q !== 4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_reload: q=%0d busy=%b, want q=4 busy=1", q, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    load_valid = 1'b1; load_value = 8;
    tick();
    load_value = 3; en = 1'b1;
    tick();
    total++;
    if (q !== 7 || load_ready !== 1'b0) begin
      bad++;
      $display("FAIL run_ignores_load: q=%0d rdy=%b, want q=7 rdy=0", q, load_ready);
    end
    load_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; en = 1'b0;
    total++;
    if (q !== 0 || busy !== 1'b0 || expired !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: q=%0d busy=%b exp=%b rdy=%b, want 0 0 0 1", q, busy, expired, load_ready);
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    load_valid = 1'b1; load_value = 2; en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (q !== ((i % 2) ? W'(1) : W'(2)) || expired !== (i % 2 == 0) || busy !== 1'b1) begin
        bad++;
        $display("FAIL auto_reload%0d: q=%0d exp=%b busy=%b", i, q, expired, busy);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    total++;
    if (busy !== 1'b0 || q !== 0) begin
      bad++;
      $display("FAIL auto_abort: busy=%b q=%0d, want 0 0", busy, q);
    end
  endtask
`endif

  task automatic test_random();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!load_valid || load_ready) begin
        load_valid = ($urandom_range(0, 3) == 0);
        load_value = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      end
      en    = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 59) != 0);
      tick();
      total++;
      if (q !== m_q || busy !== m_run || expired !== m_exp || load_ready !== !m_run) begin
        bad++;
        $display("FAIL random%0d: q=%0d busy=%b exp=%b rdy=%b, want q=%0d busy=%b exp=%b",
                 i, q, busy, expired, load_ready, m_q, m_run, m_exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load5();
    test_en_gaps();
    test_clamp_and_zero();
    test_abort();
    test_reset_mid_run();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
